// File: rtl/arp_sched_pkg.sv
// Shared types and widths for the ARP reply scheduler.
package arp_sched_pkg;

  localparam int MAC_W = 48;
  localparam int IP_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    GAP
  } state_t;

  typedef struct packed {
    logic [MAC_W-1:0] mac;
    logic [IP_W-1:0]  ip;
  } entry_t;

endpackage

// File: rtl/arp_reply_scheduler_if.sv
// Request, generator handshake and statistics bundle of the ARP reply scheduler.
interface arp_reply_scheduler_if;
  import arp_sched_pkg::*;

  logic             ENABLE;
  logic             REQ_VALID;
  logic             REQ_READY;
  logic [MAC_W-1:0] REQ_MAC;
  logic [IP_W-1:0]  REQ_IP;
  logic             GEN_START;
  logic [MAC_W-1:0] GEN_MAC;
  logic [IP_W-1:0]  GEN_IP;
  logic             GEN_DONE;
  logic             IDLE;
  logic [15:0]      STAT_SENT;
  logic [15:0]      STAT_DROPPED;
  logic [7:0]       STAT_TIMEOUT;

  // Environment side: issues requests, runs the frame generator, reads statistics.
  modport master (
    output ENABLE, REQ_VALID, REQ_MAC, REQ_IP, GEN_DONE,
    input  REQ_READY, GEN_START, GEN_MAC, GEN_IP, IDLE,
    input  STAT_SENT, STAT_DROPPED, STAT_TIMEOUT
  );

  // Scheduler side.
  modport slave (
    input  ENABLE, REQ_VALID, REQ_MAC, REQ_IP, GEN_DONE,
    output REQ_READY, GEN_START, GEN_MAC, GEN_IP, IDLE,
    output STAT_SENT, STAT_DROPPED, STAT_TIMEOUT
  );

endinterface

// File: rtl/arp_req_fifo.sv
// Pending ARP request queue. The head stays resident until popped so that an
// in-flight request still takes part in the duplicate IP comparison.
module arp_req_fifo
  import arp_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 push_entry,
  input  logic                   pop,
  input  logic [IP_W-1:0]        cmp_ip,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   dup
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_pop;
  logic [PTR_W-1:0] off;

  // Next-state of storage, pointers and occupancy; pointers wrap naturally.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Parallel IP compare over the occupied slots (offset from head < count).
  always_comb begin
    dup = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) && (mem_q[i].ip == cmp_ip)) begin
        dup = 1'b1;
      end
    end
  end

  // Control state: pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are qualified by occupancy, so no reset needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/arp_reply_scheduler.sv
// Launches one ARP reply at a time from the pending queue, with inter-frame gap,
// generator timeout recovery and saturating statistics.
module arp_reply_scheduler
  import arp_sched_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 12,
  parameter int TIMEOUT    = 2048
) (
  input logic                  CLK_TX,
  input logic                  ARESET,
  arp_reply_scheduler_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [MAC_W-1:0] gen_mac_q, gen_mac_d;
  logic [IP_W-1:0]  gen_ip_q, gen_ip_d;
  logic [15:0]      sent_q, sent_d;
  logic [15:0]      dropped_q, dropped_d;
  logic [7:0]       timeouts_q, timeouts_d;

  entry_t           fifo_head;
  entry_t           req_entry;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_dup;
  logic             req_ready;
  logic             accept;
  logic             drop;
  logic             load;
  logic             pop;
  logic             gen_start;
  logic             sent_inc;
  logic             tmo_inc;

  assign req_entry = '{mac: bus.REQ_MAC, ip: bus.REQ_IP};
  assign req_ready = fifo_count < CNT_W'(DEPTH);
  assign accept    = bus.REQ_VALID && req_ready && !fifo_dup;
  assign drop      = bus.REQ_VALID && (!req_ready || fifo_dup);

  arp_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (CLK_TX),
    .rst        (ARESET),
    .push       (accept),
    .push_entry (req_entry),
    .pop        (pop),
    .cmp_ip     (bus.REQ_IP),
    .head       (fifo_head),
    .count      (fifo_count),
    .dup        (fifo_dup)
  );

  // FSM state register.
  always_ff @(posedge CLK_TX) begin
    if (ARESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: ENABLE only gates leaving IDLE; GEN_DONE beats the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.ENABLE && (fifo_count != '0)) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_DONE;
      WAIT_DONE: if (bus.GEN_DONE || (tmo_q == TMO_LAST)) state_d = GAP;
      GAP:       if (gap_q == '0) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM outputs and counter updates per state.
  always_comb begin
    load      = 1'b0;
    pop       = 1'b0;
    gen_start = 1'b0;
    sent_inc  = 1'b0;
    tmo_inc   = 1'b0;
    tmo_d     = tmo_q;
    gap_d     = gap_q;
    case (state_q)
      IDLE: begin
        load = bus.ENABLE && (fifo_count != '0);
      end
      LAUNCH: begin
        gen_start = 1'b1;
        tmo_d     = '0;
      end
      WAIT_DONE: begin
        if (bus.GEN_DONE) begin
          pop      = 1'b1;
          sent_inc = 1'b1;
          gap_d    = GAP_LAST;
        end else if (tmo_q == TMO_LAST) begin
          pop     = 1'b1;
          tmo_inc = 1'b1;
          gap_d   = GAP_LAST;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q != '0) gap_d = gap_q - 1'b1;
      end
      default: ;
    endcase
  end

  // Target registers hold from launch until the next launch; statistics saturate.
  always_comb begin
    gen_mac_d  = load ? fifo_head.mac : gen_mac_q;
    gen_ip_d   = load ? fifo_head.ip  : gen_ip_q;
    sent_d     = sent_inc ? sat_inc16(sent_q) : sent_q;
    dropped_d  = drop ? sat_inc16(dropped_q) : dropped_q;
    timeouts_d = tmo_inc ? sat_inc8(timeouts_q) : timeouts_q;
  end

  // Counters, target registers and statistics.
  always_ff @(posedge CLK_TX) begin
    if (ARESET) begin
      tmo_q      <= '0;
      gap_q      <= '0;
      gen_mac_q  <= '0;
      gen_ip_q   <= '0;
      sent_q     <= '0;
      dropped_q  <= '0;
      timeouts_q <= '0;
    end else begin
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      gen_mac_q  <= gen_mac_d;
      gen_ip_q   <= gen_ip_d;
      sent_q     <= sent_d;
      dropped_q  <= dropped_d;
      timeouts_q <= timeouts_d;
    end
  end

  assign bus.REQ_READY    = req_ready;
  assign bus.GEN_START    = gen_start;
  assign bus.GEN_MAC      = gen_mac_q;
  assign bus.GEN_IP       = gen_ip_q;
  assign bus.IDLE         = (state_q == IDLE) && (fifo_count == '0);
  assign bus.STAT_SENT    = sent_q;
  assign bus.STAT_DROPPED = dropped_q;
  assign bus.STAT_TIMEOUT = timeouts_q;

endmodule
